// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: each sample travels with its valid bit and
// emerges exactly D cycles later; loading a new delay flushes everything in flight.
module prog_delay_line #(
    parameter int DATA_W      = 48,
    parameter int MAX_DELAY   = 64,
    parameter int RESET_DELAY = 15,
    parameter int DELAY_W     = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               valid_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic               delay_load_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               valid_o,
    output logic [DELAY_W-1:0] delay_o,
    output logic               busy_o,
    output logic               clamp_o
);

    localparam int PTR_W = $clog2(MAX_DELAY);
    localparam int EXT_W = DELAY_W + 1;

    logic [PTR_W-1:0]     wp_reg;
    logic [PTR_W-1:0]     wp_next;
    logic [PTR_W-1:0]     rd_idx;
    logic [EXT_W-1:0]     wp_ext;
    logic [EXT_W-1:0]     delay_ext;
    logic [EXT_W-1:0]     rd_ext;

    logic [DELAY_W-1:0]   delay_reg;
    logic [DELAY_W-1:0]   delay_next;
    logic [DELAY_W-1:0]   fill_reg;
    logic [DELAY_W-1:0]   fill_next;
    logic                 clamp_reg;
    logic                 clamp_next;
    logic                 req_zero;
    logic                 req_big;

    logic [MAX_DELAY-1:0] vbit_reg;
    logic [MAX_DELAY-1:0] vbit_next;
    logic                 valid_out_reg;
    logic                 valid_out_next;

    logic [DATA_W-1:0]    mem [MAX_DELAY];
    logic [DATA_W-1:0]    rd_data_reg;

    // Slot wp - D still holds the sample written D edges ago (read-before-write),
    // which also covers D = MAX_DELAY where read and write slots coincide.
    always_comb begin
        wp_ext    = EXT_W'(wp_reg);
        delay_ext = EXT_W'(delay_reg);
        rd_ext    = '0;
        if (wp_ext >= delay_ext) begin
            rd_ext = wp_ext - delay_ext;
        end else begin
            rd_ext = wp_ext + EXT_W'(MAX_DELAY) - delay_ext;
        end
        rd_idx = rd_ext[PTR_W-1:0];
    end

    always_comb begin
        wp_next = (wp_reg == PTR_W'(MAX_DELAY - 1)) ? '0 : wp_reg + PTR_W'(1);
    end

    always_comb begin
        req_zero   = (delay_i == '0);
        req_big    = (delay_i > DELAY_W'(MAX_DELAY));
        delay_next = delay_reg;
        fill_next  = fill_reg;
        clamp_next = 1'b0;
        valid_out_next = vbit_reg[rd_idx];
        if (delay_load_i) begin
            if (req_zero) begin
                delay_next = DELAY_W'(1);
            end else if (req_big) begin
                delay_next = DELAY_W'(MAX_DELAY);
            end else begin
                delay_next = delay_i;
            end
            fill_next      = '0;
            clamp_next     = req_zero | req_big;
            valid_out_next = 1'b0;
        end else if (fill_reg < delay_reg) begin
            fill_next = fill_reg + DELAY_W'(1);
        end
    end

    // On a load every slot is invalidated except the one taking this cycle's sample.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_vbit
            assign vbit_next[gi] = (wp_reg == PTR_W'(gi)) ? valid_i :
                                   (delay_load_i ? 1'b0 : vbit_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_reg        <= '0;
            delay_reg     <= DELAY_W'(RESET_DELAY);
            fill_reg      <= '0;
            clamp_reg     <= 1'b0;
            vbit_reg      <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            wp_reg        <= wp_next;
            delay_reg     <= delay_next;
            fill_reg      <= fill_next;
            clamp_reg     <= clamp_next;
            vbit_reg      <= vbit_next;
            valid_out_reg <= valid_out_next;
        end
    end

    // Sample storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        mem[wp_reg] <= data_i;
        rd_data_reg <= mem[rd_idx];
    end

    assign data_o  = valid_out_reg ? rd_data_reg : '0;
    assign valid_o = valid_out_reg;
    assign delay_o = delay_reg;
    assign busy_o  = (fill_reg < delay_reg);
    assign clamp_o = clamp_reg;

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: history-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_prog_delay_line;

    localparam int DATA_W      = 48;
    localparam int MAX_DELAY   = 64;
    localparam int RESET_DELAY = 15;
    localparam int DELAY_W     = 7;
    localparam int NHIST       = 8192;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [DATA_W-1:0]  data_i;
    logic               valid_i;
    logic [DELAY_W-1:0] delay_i;
    logic               delay_load_i;
    logic [DATA_W-1:0]  data_o;
    logic               valid_o;
    logic [DELAY_W-1:0] delay_o;
    logic               busy_o;
    logic               clamp_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prog_delay_line #(
        .DATA_W(DATA_W),
        .MAX_DELAY(MAX_DELAY),
        .RESET_DELAY(RESET_DELAY)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .delay_i(delay_i),
        .delay_load_i(delay_load_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .delay_o(delay_o),
        .busy_o(busy_o),
        .clamp_o(clamp_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers every input by edge number and derives the
    // output at edge m from the sample taken at edge m-D.
    logic [DATA_W-1:0] hist_d [NHIST];
    logic              hist_v [NHIST];
    int                m_edge   = 0;
    int                d_model  = RESET_DELAY;
    int                first_ok = 0;
    int                clr_edge = 0;

    initial begin
        logic [DATA_W-1:0] e_data;
        logic              e_valid;
        logic              e_busy;
        logic              e_clamp;
        int                n;
        forever begin
            @(posedge clk);
            hist_d[m_edge % NHIST] = data_i;
            hist_v[m_edge % NHIST] = valid_i;
            e_data  = '0;
            e_valid = 1'b0;
            e_clamp = 1'b0;
            if (rst_i) begin
                d_model  = RESET_DELAY;
                first_ok = m_edge + 1;
                clr_edge = m_edge;
            end else if (delay_load_i) begin
                if (int'(delay_i) == 0) d_model = 1;
                else if (int'(delay_i) > MAX_DELAY) d_model = MAX_DELAY;
                else d_model = int'(delay_i);
                e_clamp  = (int'(delay_i) == 0) || (int'(delay_i) > MAX_DELAY);
                first_ok = m_edge;
                clr_edge = m_edge;
            end else begin
                n = m_edge - d_model;
                if (n >= 0 && n >= first_ok && hist_v[n % NHIST]) begin
                    e_valid = 1'b1;
                    e_data  = hist_d[n % NHIST];
                end
            end
            e_busy = (m_edge - clr_edge) < d_model;
            m_edge++;
            @(negedge clk);
            chk("model_data",  64'(data_o),  64'(e_data));
            chk("model_valid", 64'(valid_o), 64'(e_valid));
            chk("model_delay", 64'(delay_o), 64'(d_model));
            chk("model_busy",  64'(busy_o),  64'(e_busy));
            chk("model_clamp", 64'(clamp_o), 64'(e_clamp));
        end
    end

    task automatic drive(input logic r, input logic ld, input int dly,
                         input logic v, input logic [DATA_W-1:0] d);
        rst_i        = r;
        delay_load_i = ld;
        delay_i      = DELAY_W'(dly);
        valid_i      = v;
        data_i       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_i = 1'b1; delay_load_i = 1'b0; delay_i = '0; valid_i = 1'b0; data_i = '0;

        repeat (3) drive(1'b1, 1'b0, 0, 1'b0, '0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data",  64'(data_o),  64'd0);
        chk("rst_delay", 64'(delay_o), 64'd15);
        chk("rst_busy",  64'(busy_o),  64'd1);
        chk("rst_clamp", 64'(clamp_o), 64'd0);

        // Default delay ramp
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(k));
            if (k == 15) chk("ramp_pre_valid", 64'(valid_o), 64'd0);
            if (k == 16) begin
                chk("ramp_first_data",  64'(data_o),  64'd1);
                chk("ramp_first_valid", 64'(valid_o), 64'd1);
                chk("ramp_busy_low",    64'(busy_o),  64'd0);
            end
            if (k == 17) chk("ramp_second", 64'(data_o), 64'd2);
        end

        // Minimum delay
        drive(1'b0, 1'b1, 1, 1'b0, '0);
        chk("min_delay_o", 64'(delay_o), 64'd1);
        chk("min_clamp",   64'(clamp_o), 64'd0);
        drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(48'hA5));
        chk("min_before", 64'(data_o), 64'd0);
        drive(1'b0, 1'b0, 0, 1'b0, '0);
        chk("min_data",  64'(data_o),  64'hA5);
        chk("min_valid", 64'(valid_o), 64'd1);
        drive(1'b0, 1'b0, 0, 1'b0, '0);
        chk("min_after", 64'(data_o), 64'd0);

        // Clamping
        drive(1'b0, 1'b1, 0, 1'b0, '0);
        chk("clamp0_delay", 64'(delay_o), 64'd1);
        chk("clamp0_pulse", 64'(clamp_o), 64'd1);
        drive(1'b0, 1'b0, 0, 1'b0, '0);
        chk("clamp0_end", 64'(clamp_o), 64'd0);
        drive(1'b0, 1'b1, 100, 1'b0, '0);
        chk("clamp100_delay", 64'(delay_o), 64'd64);
        chk("clamp100_pulse", 64'(clamp_o), 64'd1);
        for (int k = 1; k <= 200; k++) begin
            drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(1000 + k));
            if (k == 64) chk("max_pre_valid", 64'(valid_o), 64'd0);
            if (k == 65) chk("max_first", 64'(data_o), 64'd1001);
            if (k == 130) chk("max_wrap", 64'(data_o), 64'd1066);
        end

        // Mid-stream delay change
        drive(1'b0, 1'b1, 15, 1'b0, '0);
        for (int k = 1; k <= 49; k++) drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(k));
        drive(1'b0, 1'b1, 4, 1'b1, DATA_W'(50));
        for (int k = 51; k <= 70; k++) begin
            drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(k));
            if (k == 53) chk("mid_pre_valid", 64'(valid_o), 64'd0);
            if (k == 54) chk("mid_first", 64'(data_o), 64'd50);
        end

        // Valid gaps
        drive(1'b0, 1'b1, 8, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, pat[i], DATA_W'(10 + i));
        for (int j = 1; j <= 10; j++) begin
            drive(1'b0, 1'b0, 0, 1'b0, '0);
            if (j == 4) chk("gap_d10", 64'(data_o), 64'd10);
            if (j == 5) chk("gap_v0",  64'(valid_o), 64'd0);
            if (j == 6) chk("gap_d12", 64'(data_o), 64'd12);
            if (j == 7) chk("gap_d13", 64'(data_o), 64'd13);
            if (j == 8) chk("gap_d0",  64'(data_o), 64'd0);
        end

        // Reset mid-operation
        drive(1'b0, 1'b1, 20, 1'b0, '0);
        for (int k = 1; k <= 40; k++) drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(500 + k));
        drive(1'b1, 1'b0, 0, 1'b1, DATA_W'(999));
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_data",  64'(data_o),  64'd0);
        chk("midrst_delay", 64'(delay_o), 64'd15);
        for (int k = 1; k <= 40; k++) drive(1'b0, 1'b0, 0, 1'b1, DATA_W'(700 + k));

        // Random traffic with occasional loads and resets
        for (int k = 0; k < 4000; k++) begin
            drive($urandom_range(0, 599) == 0,
                  $urandom_range(0, 79) == 0,
                  int'($urandom_range(0, 127)),
                  $urandom_range(0, 3) != 0,
                  DATA_W'({$urandom(), $urandom()}));
        end
        drive(1'b0, 1'b0, 0, 1'b0, '0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
